// File: rtl/mmio_fabric_pkg.sv
// Shared MiniLab address map, fabric state encoding and small helpers.
package MiniLab_defs;

   localparam logic [15:0] MMIO_BASE    = 16'hC000;
   localparam logic [15:0] STATUS_ADDR  = 16'hCFFF;
   localparam int          DMEM_DEPTH   = 12;
   localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

   typedef enum logic [1:0] {
      FAB_IDLE,
      FAB_ACCESS,
      FAB_RESP
   } fab_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mmio_fabric_if.sv
// Processor, data-memory and slave-window signals of the MMIO fabric bundled as one bus.
interface mmio_fabric_if #(
   parameter int NUM_SLV   = 4,
   parameter int WIN_WORDS = 4,
   localparam int OFF_W    = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1
);

   logic [15:0]           daddr;
   logic                  we;
   logic                  re;
   logic [15:0]           wdata;
   logic [15:0]           rdata;
   logic                  stall;
   logic                  err;
   logic                  dmem_we;
   logic [15:0]           dmem_rdata;
   logic [NUM_SLV-1:0]    slv_sel;
   logic                  slv_we;
   logic [OFF_W-1:0]      slv_off;
   logic [15:0]           slv_wdata;
   logic [NUM_SLV*16-1:0] slv_rdata;
   logic [NUM_SLV-1:0]    slv_ready;

   // Environment side: processor, data memory and slaves.
   modport master (
      output daddr, we, re, wdata, dmem_rdata, slv_rdata, slv_ready,
      input  rdata, stall, err, dmem_we, slv_sel, slv_we, slv_off, slv_wdata
   );

   // Fabric side.
   modport slave (
      input  daddr, we, re, wdata, dmem_rdata, slv_rdata, slv_ready,
      output rdata, stall, err, dmem_we, slv_sel, slv_we, slv_off, slv_wdata
   );

endinterface

// File: rtl/mmio_fabric.sv
// Address decoder + slave access FSM: DMEM/status/unmapped answer in 0 wait; slave access takes
// 2+N cycles with stall_o held until the RESP cycle, bus error after TIMEOUT ACCESS cycles.
module mmio_fabric #(
   parameter int NUM_SLV    = 4,
   parameter int WIN_WORDS  = 4,
   parameter int TIMEOUT    = 15,
   parameter int DMEM_DEPTH = MiniLab_defs::DMEM_DEPTH,
   localparam int OFF_W     = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           daddr_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [15:0]           wdata_i,
   output logic [15:0]           rdata_o,
   output logic                  stall_o,
   output logic                  err_o,
   output logic                  dmem_we_o,
   input  logic [15:0]           dmem_rdata_i,
   output logic [NUM_SLV-1:0]    slv_sel_o,
   output logic                  slv_we_o,
   output logic [OFF_W-1:0]      slv_off_o,
   output logic [15:0]           slv_wdata_o,
   input  logic [NUM_SLV*16-1:0] slv_rdata_i,
   input  logic [NUM_SLV-1:0]    slv_ready_i
);

   import MiniLab_defs::*;

   localparam int          IDX_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int          CNT_W    = $clog2(TIMEOUT + 1);
   localparam int          OFF_SH   = $clog2(WIN_WORDS);
   localparam logic [15:0] SLV_SPAN = 16'(NUM_SLV * WIN_WORDS);

   logic                req;
   logic                is_dmem;
   logic                is_stat;
   logic                is_slv;
   logic [15:0]         rel;
   logic [IDX_W-1:0]    dec_idx;
   logic [OFF_W-1:0]    dec_off;
   logic [NUM_SLV-1:0]  dec_onehot;

   fab_state_t          state;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    cnt;
   logic [15:0]         resp;
   logic                resp_err;
   logic [7:0]          err_cnt;

   always_comb begin
      req     = re_i | we_i;
      rel     = daddr_i - MMIO_BASE;
      is_dmem = (daddr_i >> DMEM_DEPTH) == 16'd0;
      is_stat = !is_dmem && (daddr_i == STATUS_ADDR);
      is_slv  = !is_dmem && !is_stat && (daddr_i >= MMIO_BASE) && (rel < SLV_SPAN);
      dec_idx = IDX_W'(rel >> OFF_SH);
      dec_off = (WIN_WORDS > 1) ? OFF_W'(rel) : '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         dec_onehot[i] = (dec_idx == IDX_W'(i));
      end
   end

   // cnt holds the number of ACCESS cycles already spent, so the TIMEOUT-th one is the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FAB_IDLE;
         idx_q       <= '0;
         cnt         <= '0;
         resp        <= '0;
         resp_err    <= 1'b0;
         err_cnt     <= '0;
         slv_sel_o   <= '0;
         slv_we_o    <= 1'b0;
         slv_off_o   <= '0;
         slv_wdata_o <= '0;
      end else begin
         case (state)
            FAB_IDLE: begin
               resp_err <= 1'b0;
               if (req && !is_dmem) begin
                  if (is_slv) begin
                     idx_q       <= dec_idx;
                     slv_sel_o   <= dec_onehot;
                     slv_we_o    <= we_i;
                     slv_off_o   <= dec_off;
                     slv_wdata_o <= wdata_i;
                     cnt         <= '0;
                     state       <= FAB_ACCESS;
                  end else if (is_stat) begin
                     if (we_i) err_cnt <= '0;
                  end else begin
                     err_cnt <= sat_inc8(err_cnt);
                  end
               end
            end
            FAB_ACCESS: begin
               if (slv_ready_i[idx_q]) begin
                  resp      <= slv_rdata_i[idx_q*16 +: 16];
                  slv_sel_o <= '0;
                  state     <= FAB_RESP;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  resp      <= BUS_ERR_DATA;
                  resp_err  <= 1'b1;
                  err_cnt   <= sat_inc8(err_cnt);
                  slv_sel_o <= '0;
                  state     <= FAB_RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FAB_RESP: begin
               resp_err <= 1'b0;
               state    <= FAB_IDLE;
            end
            default: begin
               slv_sel_o <= '0;
               state     <= FAB_IDLE;
            end
         endcase
      end
   end

   // Outputs are forced quiet while reset is asserted, even if a request is still held.
   always_comb begin
      rdata_o   = '0;
      stall_o   = 1'b0;
      err_o     = 1'b0;
      dmem_we_o = 1'b0;
      if (rst_n) begin
         case (state)
            FAB_IDLE: begin
               if (req) begin
                  if (is_dmem) begin
                     dmem_we_o = we_i;
                     rdata_o   = dmem_rdata_i;
                  end else if (is_stat) begin
                     rdata_o = {8'h00, err_cnt};
                  end else if (is_slv) begin
                     stall_o = 1'b1;
                  end else begin
                     err_o = 1'b1;
                  end
               end
            end
            FAB_ACCESS: stall_o = 1'b1;
            FAB_RESP: begin
               rdata_o = resp;
               err_o   = resp_err;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mmio_fabric.md
MMIO_FABRIC -- requirements
Module: mmio_fabric

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4, number of MMIO slave windows (1..8).
REQ-002 SHALL have parameter WIN_WORDS, default 4, words per slave window (power of 2).
REQ-003 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles before bus error.
REQ-004 SHALL have parameter DMEM_DEPTH, default from shared package, physical data memory address width.
REQ-005 SHALL have port clk, input, 1, system clock; the design is single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports daddr_i in 16, we_i in 1, re_i in 1, wdata_i in 16: processor request.
REQ-008 SHALL have ports rdata_o out 16, stall_o out 1, err_o out 1: processor response.
REQ-009 SHALL have ports dmem_we_o out 1 and dmem_rdata_i in 16: physical memory.
REQ-010 SHALL have ports slv_sel_o out NUM_SLV, slv_we_o out 1, slv_off_o out log2(WIN_WORDS), slv_wdata_o out 16: slave request.
REQ-011 SHALL have ports slv_rdata_i in NUM_SLV*16 (slave i at bits [16i+15:16i]) and slv_ready_i in NUM_SLV.

Function
REQ-012 SHALL decode an address as DMEM when daddr_i[15:DMEM_DEPTH]==0: dmem_we_o=we_i, rdata_o=dmem_rdata_i combinationally, stall_o=0.
REQ-013 SHALL decode slave i when daddr_i is in [MMIO_BASE+i*WIN_WORDS, MMIO_BASE+(i+1)*WIN_WORDS-1], offset = daddr_i minus window base.
REQ-014 SHALL decode STATUS_ADDR as the fabric status register, zero wait: read returns {8'h00, err_cnt}, write clears err_cnt to 0.
REQ-015 SHALL treat every other non-DMEM address as unmapped: no stall, rdata_o=0, err_o=1 for that cycle, err_cnt increments.
REQ-016 SHALL implement FSM IDLE, ACCESS, RESP; requests (re_i|we_i) are accepted only in IDLE.
REQ-017 IDLE + slave request: stall_o=1 combinationally, latch slave index, offset, wdata, we; next state ACCESS, timeout counter cleared.
REQ-018 ACCESS: slv_sel_o one-hot from latched index, slv_we_o/slv_off_o/slv_wdata_o from latched values, stall_o=1, counter increments each cycle.
REQ-019 ACCESS with slv_ready_i[idx]=1: capture slv_rdata_i slice into response register, next state RESP.
REQ-020 ACCESS with counter==TIMEOUT and no ready: response register=16'hDEAD, err_o=1 in the RESP cycle, err_cnt increments, next state RESP.
REQ-021 RESP: slv_sel_o=0, stall_o=0, rdata_o=response register, unconditional return to IDLE; requests present in RESP are ignored.
REQ-022 Slave request latency SHALL be 2+N cycles with N ACCESS cycles before ready; ready in first ACCESS cycle gives 2.
REQ-023 err_cnt SHALL be 8 bits, saturating at 8'hFF; clear and increment never coincide (status access impossible while stalled).
REQ-024 slv_sel_o SHALL be zero outside ACCESS; at most one bit set.
REQ-025 Writes to slaves SHALL return rdata_o = captured slv_rdata_i value (don't-care to processor).

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, slv_sel_o=0, stall_o=0, err_o=0, rdata_o=0 (when no request), err_cnt=0, response register=0.
REQ-027 Reset during ACCESS SHALL abort the transaction with no err_cnt change and no slave select after deassertion.

Structure
REQ-028 MMIO_BASE (16'hC000), STATUS_ADDR (16'hCFFF), DMEM_DEPTH and the fabric state enum SHALL live in package MiniLab_defs.
REQ-029 The block SHALL be a single module; no sub-module.

Verification
REQ-030 re_i=1, daddr_i=16'h0010, dmem_rdata_i=16'h1234 -> rdata_o=16'h1234 same cycle, stall_o=0.
REQ-031 re_i to slave 1 offset 2 (16'hC006), ready after 3 ACCESS cycles with 16'h00A5 -> stall_o high 4 cycles, RESP rdata_o=16'h00A5, slv_off_o=2.
REQ-032 we_i to slave 0, ready never asserted -> stall 1+15 cycles, RESP err_o=1, rdata_o=16'hDEAD, status reads 1.
REQ-033 re_i to 16'hC800 (unmapped) 256 times -> err_o each, status reads 8'hFF (saturated); write STATUS_ADDR -> reads 0.
REQ-034 rst_n low mid-ACCESS -> slv_sel_o=0, stall_o=0 immediately; after release next request served normally, err_cnt=0.
